mul_dot_seq: RTL and testbench

- Sequencer that time-shares one 32x32 Vedic multiplier datapath (operand PIPO stage, multiplier, result PIPO stage) to compute dot products of VEC_LEN operand pairs for the matrix multiplier.
- Accepts operand pairs over a valid/ready handshake and issues one multiply at a time. It waits for the datapath's done pulse, then accumulates the product.
- Presents the finished sum over a valid/ready handshake.

---
 rtl/mul_dot_seq.sv | 166 ++++++++++++++++
 tb/tb_mul_dot_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_dot_seq.sv
// Dot-product sequencer: feeds operand pairs one at a time to a shared multiplier
// datapath, accumulates the returned products and hands the sum to a consumer.
module mul_dot_seq #(
    parameter int W       = 32,
    parameter int VEC_LEN = 4,
    parameter int ACC_W   = 72,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       a_in,
    input  logic [W-1:0]       b_in,
    output logic [W-1:0]       mul_a,
    output logic [W-1:0]       mul_b,
    output logic               mul_start,
    input  logic [2*W-1:0]     mul_product,
    input  logic               mul_done,
    output logic [ACC_W-1:0]   acc_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               err_timeout
);

    localparam int CNT_W = 8;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] VEC_C = CNT_W'(VEC_LEN);
    localparam logic [TMO_W-1:0] TMO_C = TMO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_ACCUM  = 3'd3,
        S_OUTPUT = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [2*W-1:0]     prod_q, prod_d;
    logic [W-1:0]       mul_a_q, mul_a_d;
    logic [W-1:0]       mul_b_q, mul_b_d;
    logic               err_q, err_d;
    logic               in_ready_q, in_ready_d;
    logic               mul_start_q, mul_start_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        tmo_d     = tmo_q;
        prod_d    = prod_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    mul_a_d = a_in;
                    mul_b_d = b_in;
                    if (count_q == {CNT_W{1'b0}}) begin
                        acc_d = {ACC_W{1'b0}};
                    end else begin
                        acc_d = acc_q;
                    end
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                tmo_d   = {TMO_W{1'b0}};
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tmo_d = tmo_q + TMO_W'(1);
                // A done pulse on the final cycle still counts as in time.
                if (mul_done) begin
                    prod_d  = mul_product;
                    state_d = S_ACCUM;
                end else if (tmo_q + TMO_W'(1) == TMO_C) begin
                    err_d   = 1'b1;
                    acc_d   = {ACC_W{1'b0}};
                    count_d = {CNT_W{1'b0}};
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ACCUM: begin
                acc_d   = acc_q + ACC_W'(prod_q);
                count_d = count_q + CNT_W'(1);
                if (count_d == VEC_C) begin
                    state_d = S_OUTPUT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OUTPUT: begin
                if (out_valid_q && out_ready) begin
                    count_d = {CNT_W{1'b0}};
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OUTPUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        mul_start_d = (state_d == S_ISSUE);
        out_valid_d = (state_d == S_OUTPUT);
        busy_d      = (state_d != S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            count_q     <= {CNT_W{1'b0}};
            acc_q       <= {ACC_W{1'b0}};
            tmo_q       <= {TMO_W{1'b0}};
            prod_q      <= {(2*W){1'b0}};
            mul_a_q     <= {W{1'b0}};
            mul_b_q     <= {W{1'b0}};
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            mul_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            tmo_q       <= tmo_d;
            prod_q      <= prod_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            mul_start_q <= mul_start_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign mul_start   = mul_start_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign acc_out     = acc_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_mul_dot_seq.sv
// Randomized bench for mul_dot_seq with a multiplier-datapath model and a
// plain-arithmetic dot-product reference.
module tb_mul_dot_seq;

    localparam int W     = 32;
    localparam int VL    = 4;
    localparam int ACC_W = 72;
    localparam int TMO   = 64;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [W-1:0]       a_in = '0;
    logic [W-1:0]       b_in = '0;
    logic [W-1:0]       mul_a, mul_b;
    logic               mul_start;
    logic [2*W-1:0]     mul_product = '0;
    logic               mul_done = 1'b0;
    logic [ACC_W-1:0]   acc_out;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               busy;
    logic               err_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // datapath model controls
    int  dp_delay  = 2;
    bit  dp_hang   = 1'b0;
    int  spur_req  = 0;
    int  start_cnt = 0;
    int  wide_cnt  = 0;

    logic [W-1:0]     va [VL];
    logic [W-1:0]     vb [VL];
    logic [ACC_W-1:0] ref_sum;

    mul_dot_seq #(.W(W), .VEC_LEN(VL), .ACC_W(ACC_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .mul_a(mul_a), .mul_b(mul_b),
        .mul_start(mul_start), .mul_product(mul_product), .mul_done(mul_done),
        .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Multiplier datapath: product of the issued operands after dp_delay cycles.
    initial begin
        bit             pend = 1'b0;
        int             cd = 0;
        int             spur_ack = 0;
        logic [2*W-1:0] pprod = '0;
        forever begin
            @(negedge clk);
            mul_done = 1'b0;
            if (!reset) begin
                pend = 1'b0;
            end else if (pend) begin
                if (cd <= 1) begin
                    mul_done    = 1'b1;
                    mul_product = pprod;
                    pend        = 1'b0;
                end else begin
                    cd--;
                end
            end else if (spur_req != spur_ack) begin
                spur_ack++;
                mul_done    = 1'b1;
                mul_product = {$urandom, $urandom};
            end
            if (reset && mul_start && !dp_hang) begin
                pend  = 1'b1;
                cd    = dp_delay;
                pprod = 64'(mul_a) * 64'(mul_b);
            end
        end
    end

    // Count start pulses and flag any pulse longer than one cycle.
    initial begin
        bit prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mul_start) begin
                start_cnt++;
                if (prev) wide_cnt++;
            end
            prev = mul_start;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        int t = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("send_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        @(negedge clk);
        in_valid = 1'b0;
        a_in     = $urandom;
        b_in     = $urandom;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        check(tag, in_ready, 1'b1);
    endtask

    task automatic send_vec();
        ref_sum = '0;
        for (int i = 0; i < VL; i++) begin
            send_pair(va[i], vb[i]);
            ref_sum = ref_sum + ACC_W'(va[i]) * ACC_W'(vb[i]);
        end
    endtask

    task automatic take_result(input string tag, input logic [ACC_W-1:0] exp, input int stall,
                               input bit spur);
        int t = 0;
        while (!out_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_sum"}, acc_out, exp);
        if (spur) spur_req++;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, {out_valid, in_ready, busy, acc_out}, {3'b101, exp});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_release"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        int base;
        int cyc;
        logic [ACC_W-1:0] part;

        // reset held for three cycles
        repeat (3) begin
            @(negedge clk);
            check("rst_ctl", {in_ready, mul_start, out_valid, busy, err_timeout}, 5'b0);
            check("rst_data", {mul_a, mul_b, acc_out}, 136'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("rel_ready", {in_ready, busy}, 2'b10);

        // basic vector
        base = start_cnt;
        va = '{32'd1, 32'd3, 32'd5, 32'd7};
        vb = '{32'd2, 32'd4, 32'd6, 32'd8};
        send_vec();
        take_result("basic", 72'd100, 0, 1'b0);
        check("basic_starts", start_cnt - base, 4);
        check("start_width", wide_cnt, 0);

        // max operands with backpressure and a stray done while stalled
        for (int i = 0; i < VL; i++) begin
            va[i] = 32'hFFFF_FFFF;
            vb[i] = 32'hFFFF_FFFF;
        end
        send_vec();
        take_result("max", 72'h3_FFFF_FFF8_0000_0004, 5, 1'b1);

        // timeout: the datapath never answers
        check("err_pre", err_timeout, 1'b0);
        dp_hang = 1'b1;
        send_pair($urandom, $urandom);
        cyc = 0;
        while (!err_timeout && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("tmo_cycles", cyc - 1, TMO);
        check("tmo_idle", {err_timeout, in_ready, busy}, 3'b110);
        dp_hang = 1'b0;
        for (int i = 0; i < VL; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
        end
        send_vec();
        take_result("post_tmo", ref_sum, 1, 1'b0);
        check("err_sticky", err_timeout, 1'b1);

        // reset after the second accumulate, then a fresh vector
        send_pair($urandom, $urandom);
        send_pair($urandom, $urandom);
        wait_idle("mid_idle");
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_rst", {in_ready, busy, out_valid, err_timeout, acc_out}, 76'd0);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < VL; i++) begin
            va[i] = 32'd1;
            vb[i] = 32'd1;
        end
        send_vec();
        take_result("mid", 72'd4, 0, 1'b0);

        // stray done while idle in the middle of a vector
        for (int i = 0; i < VL; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
        end
        ref_sum = '0;
        for (int i = 0; i < VL; i++) begin
            send_pair(va[i], vb[i]);
            ref_sum = ref_sum + ACC_W'(va[i]) * ACC_W'(vb[i]);
            if (i == 1) begin
                wait_idle("spur_idle");
                spur_req++;
                repeat (3) @(negedge clk);
            end
        end
        take_result("spur", ref_sum, 2, 1'b0);

        // randomized vectors with varying datapath latency and stalls
        for (int v = 0; v < 6; v++) begin
            dp_delay = $urandom_range(1, 5);
            for (int i = 0; i < VL; i++) begin
                va[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                vb[i] = $urandom;
            end
            part = '0;
            send_vec();
            take_result("rand", ref_sum, $urandom_range(0, 3), 1'b0);
        end
        check("rand_width", wide_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
